// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LW_STALL = 2'd1,
        MC_WAIT  = 2'd2
    } hsc_state_t;

    // Watchdog width; holds values up to max_cycles-1.
    function automatic int unsigned hsc_wd_width(input int unsigned max_cycles);
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/hsc_sat_counter.sv
// Saturating event counter: counts i_inc cycles and holds at all-ones.
module hsc_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Optional perf counters are built when HSC_PERF_CNT_EN is defined.
module hazard_stall_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MC_MAX_CYCLES = 32,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lw_stall,
    input  logic             mc_start,
    input  logic             mc_done,
    input  logic             branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             mc_busy,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] lw_stall_cnt,
    output logic [CNT_W-1:0] mc_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WD_W = hsc_wd_width(MC_MAX_CYCLES);

    hsc_state_t       r_state;
    hsc_state_t       w_state_next;
    logic [WD_W-1:0]  r_wd;
    logic             r_timeout;
    logic             w_wd_expired;
    logic             w_timeout_set;

    assign w_wd_expired = (r_wd == WD_W'(MC_MAX_CYCLES - 1));

    always_comb begin
        w_state_next  = r_state;
        w_timeout_set = 1'b0;
        pc_we         = 1'b0;
        ifid_we       = 1'b0;
        idex_we       = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;
        mc_busy       = 1'b0;
        if (!rst) begin
            case (r_state)
                MC_WAIT: begin
                    mc_busy = 1'b1;
                    if (mc_done || w_wd_expired) begin
                        pc_we         = 1'b1;
                        ifid_we       = 1'b1;
                        idex_we       = 1'b1;
                        w_timeout_set = !mc_done;
                        w_state_next  = RUN;
                    end else begin
                        exmem_bubble = 1'b1;
                    end
                end
                // RUN, LW_STALL and the unused encoding share one decode.
                default: begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    idex_we = 1'b1;
                    if (branch_taken) begin
                        ifid_flush   = 1'b1;
                        idex_bubble  = 1'b1;
                        w_state_next = RUN;
                    end else if (lw_stall && (r_state != LW_STALL)) begin
                        pc_we        = 1'b0;
                        ifid_we      = 1'b0;
                        idex_bubble  = 1'b1;
                        w_state_next = LW_STALL;
                    end else if (mc_start) begin
                        w_state_next = MC_WAIT;
                    end else begin
                        w_state_next = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Held at zero outside MC_WAIT, so every op starts from a cleared watchdog.
            if (r_state != MC_WAIT) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign mc_timeout = r_timeout;

`ifdef HSC_PERF_CNT_EN
    logic w_lw_evt;
    logic w_mc_evt;
    logic w_flush_evt;

    // A bubble without a flush can only come from a load-use stall.
    assign w_lw_evt    = idex_bubble && !ifid_flush;
    assign w_mc_evt    = mc_busy && !mc_done;
    assign w_flush_evt = ifid_flush;

    hsc_sat_counter #(.CNT_W(CNT_W)) u_lw_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_lw_evt),
        .o_cnt (lw_stall_cnt)
    );

    hsc_sat_counter #(.CNT_W(CNT_W)) u_mc_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_mc_evt),
        .o_cnt (mc_stall_cnt)
    );

    hsc_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_flush_evt),
        .o_cnt (flush_cnt)
    );
`else
    assign lw_stall_cnt = '0;
    assign mc_stall_cnt = '0;
    assign flush_cnt    = '0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline stall/flush sequencer for the 5-stage core.
- Consumes the load-use stall flag from the forwarding/hazard unit, multicycle-unit (mul/div) handshake and EX branch resolution.
- Drives per-stage write enables, bubble inserts and IF/ID flush.
- Sits between the hazard unit and the pipeline registers; sole owner of stall/flush policy.

Parameters:
MC_MAX_CYCLES, 32, watchdog limit for a multicycle op in cycles; legal range 2..255.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
lw_stall  in  1  load-use hazard for the instruction in ID (from hazard unit).
mc_start  in  1  instruction in ID is a multicycle op.
mc_done  in  1  multicycle unit result valid, 1-cycle pulse.
branch_taken  in  1  taken branch/jump resolved in EX this cycle.
pc_we  out  1  PC write enable.
ifid_we  out  1  IF/ID register write enable.
idex_we  out  1  ID/EX register write enable.
ifid_flush  out  1  zero IF/ID contents.
idex_bubble  out  1  load NOP into ID/EX.
exmem_bubble  out  1  load NOP into EX/MEM.
mc_busy  out  1  multicycle op occupying EX.
mc_timeout  out  1  sticky watchdog flag.
lw_stall_cnt  out  CNT_W  load-use stall cycles.
mc_stall_cnt  out  CNT_W  multicycle wait cycles.
flush_cnt  out  CNT_W  branch flushes.

Behaviour:
- Control outputs are combinational from the state register plus current inputs, so they act in the same cycle.
- Only the state register, watchdog counter and perf counters are flopped.
- While rst=1: state=RUN, watchdog=0, mc_timeout=0, counters=0; every control output is 0 (pipeline frozen).
- FSM states:
  - RUN: default pc_we=ifid_we=idex_we=1; all bubble/flush outputs 0; mc_busy=0.
    - branch_taken=1: ifid_flush=1, idex_bubble=1, enables stay 1, next RUN. Highest priority; any lw_stall/mc_start the same cycle is ignored (wrong-path instruction).
    - else lw_stall=1: pc_we=ifid_we=0, idex_bubble=1, next LW_STALL.
    - else mc_start=1: instruction advances normally, next MC_WAIT, watchdog cleared to 0.
    - mc_done in RUN: ignored.
  - LW_STALL: exactly one cycle, RUN-default outputs. lw_stall is masked this cycle and cannot re-stall. branch_taken still handled as in RUN. mc_start is honoured (next MC_WAIT); otherwise next RUN.
  - MC_WAIT: pc_we=ifid_we=idex_we=0, exmem_bubble=1, mc_busy=1; watchdog increments each cycle.
    - mc_done=1: all enables 1, exmem_bubble=0 this cycle, next RUN. A done in the first wait cycle is legal, giving 1-cycle latency.
    - Watchdog reaches MC_MAX_CYCLES-1 without done: set mc_timeout; release as if done; next RUN.
    - branch_taken and lw_stall are ignored (EX is occupied); the bench asserts branch_taken never rises here.
- mc_timeout clears only on rst.
- Reset mid-MC_WAIT aborts the op immediately. Re-issue is the multicycle unit's responsibility.

Optional Feature:
HSC_PERF_CNT_EN
- Defined: three saturating counters of width CNT_W.
  - lw_stall_cnt: +1 per cycle idex_bubble is due to lw_stall.
  - mc_stall_cnt: +1 per MC_WAIT cycle without mc_done.
  - flush_cnt: +1 per branch_taken flush.
  - Each counter holds at all-ones once saturated.
- Undefined: counter ports remain present, tied to 0; no counter flops synthesised.

Decomposition:
- Package hazard_ctrl_pkg:
  - hsc_state_t enum: RUN=2'd0, LW_STALL=2'd1, MC_WAIT=2'd2 (2'd3 unreachable, decodes to RUN).
  - WD_W = $clog2(MC_MAX_CYCLES) width constant.
- Sub-module hsc_sat_counter (CNT_W, inc, rst), instantiated three times under the macro.

Test Plan:
- Reset: rst=1 with lw_stall=1 -> all controls 0. Deassert rst, no inputs -> pc_we=ifid_we=idex_we=1, state RUN.
- Load-use: lw_stall=1 for 2 consecutive cycles -> cycle0 pc_we=0, ifid_we=0, idex_bubble=1; cycle1 enables 1 (masked); lw_stall_cnt=1.
- Branch priority: branch_taken=1 with lw_stall=1 and mc_start=1 -> ifid_flush=1, idex_bubble=1, pc_we=1; next state RUN; flush_cnt=1.
- Multicycle: mc_start pulse, mc_done 5 cycles after entering MC_WAIT -> 5 cycles of pc_we=0 and exmem_bubble=1; done cycle enables 1; mc_stall_cnt=5.
- Watchdog: MC_MAX_CYCLES=4, mc_start, no mc_done -> release on 4th wait cycle; mc_timeout=1 and stays 1 until rst.
- Reset mid-op: rst asserted during MC_WAIT cycle 2 -> immediate RUN; mc_busy=0 and controls 0 while rst=1.
